// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - single-outstanding line refill engine: miss accept, burst read, beat assembly, cache fill
module cache_refill_ctrl #(
    parameter int ADDR_L = 32,
    parameter int OFS_L  = 6,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 8 * (2 ** OFS_L),
    parameter int BEATS  = LINE_W / BEAT_W,
    parameter int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_L-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req,
    output logic [ADDR_L-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rerr,
    output logic              fill_valid,
    output logic [ADDR_L-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_err,
    input  logic              fill_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_L-1:0] base_q, base_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              beat;
    logic              last_beat;

    // Offset bits never reach the memory side; the line is always fetched whole.
    logic unused_ofs;
    assign unused_ofs = ^miss_addr[OFS_L-1:0];

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        // Memory may return beat 0 before or together with the grant.
        beat      = mem_rvalid && ((state_q == S_REQ) || (state_q == S_DATA));
        last_beat = (cnt_q == CNT_W'(BEATS - 1));

        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    base_d  = {miss_addr[ADDR_L-1:OFS_L], {OFS_L{1'b0}}};
                    data_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
            end
            S_FILL: begin
                if (fill_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (beat) begin
            data_d[int'(cnt_q) * BEAT_W +: BEAT_W] = mem_rdata;
            err_d = err_q | mem_rerr;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) begin
                state_d = S_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign miss_ready = (state_q == S_IDLE);
    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = base_q;
    assign fill_valid = (state_q == S_FILL);
    assign fill_addr  = base_q;
    assign fill_data  = data_q;
    assign fill_err   = err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - table-driven refill scenarios with fill scoreboard
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;
    logic         mem_rerr;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [511:0] fill_data;
    logic         fill_err;
    logic         fill_ready;

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rerr   (mem_rerr),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_err   (fill_err),
        .fill_ready (fill_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gnt_dly;
        bit          gap;
        int          rdy_dly;
        int          err_beat;
        logic [31:0] base;
        logic [63:0] seed;
    } vec_t;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic         err;
    } fill_t;

    vec_t  vecs [8];
    fill_t sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_bursts = 0;
    logic  req_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (mem_req && !req_prev) n_bursts++;
        req_prev = mem_req;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_miss(input vec_t v);
        fill_t       e;
        fill_t       got;
        int          lat;
        int          b0;
        logic [63:0] beat;
        b0 = n_bursts;
        chk("miss_ready_idle", miss_ready, 1);
        miss_valid = 1'b1;
        miss_addr  = v.addr;
        step();
        miss_valid = 1'b0;
        lat = 1;
        e.addr = v.base;
        e.data = '0;
        e.err  = 1'b0;
        for (int d = 0; d < v.gnt_dly; d++) begin
            chk("req_hold", mem_req, 1);
            chk("req_addr_stable", mem_addr, v.base);
            step();
            lat++;
        end
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, v.base);
        mem_gnt = 1'b1;
        step();
        lat++;
        mem_gnt = 1'b0;
        chk("req_drop", mem_req, 0);
        for (int k = 0; k < 8; k++) begin
            if (v.gap) begin
                step();
                lat++;
            end
            beat = (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ v.seed;
            mem_rvalid = 1'b1;
            mem_rdata  = beat;
            mem_rerr   = (k == v.err_beat);
            e.data[64*k +: 64] = beat;
            e.err = e.err | (k == v.err_beat);
            step();
            lat++;
            mem_rvalid = 1'b0;
            mem_rerr   = 1'b0;
        end
        sb.push_back(e);
        chk("fill_valid", fill_valid, 1);
        chk("latency", lat, 10 + v.gnt_dly + (v.gap ? 8 : 0));
        for (int i = 0; i < v.rdy_dly; i++) begin
            chk("fill_hold_valid", fill_valid, 1);
            chk("fill_hold_data", fill_data, sb[0].data);
            chk("fill_hold_addr", fill_addr, sb[0].addr);
            chk("miss_ready_busy", miss_ready, 0);
            miss_valid = 1'b1;
            miss_addr  = 32'hDEAD_BEEF;
            step();
        end
        miss_valid = 1'b0;
        chk("fill_valid_hs", fill_valid, 1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got fill with no expected entry");
        end else begin
            got = sb.pop_front();
            chk("fill_addr", fill_addr, got.addr);
            chk("fill_data", fill_data, got.data);
            chk("fill_err", fill_err, got.err);
        end
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        chk("fill_drop", fill_valid, 0);
        chk("miss_ready_after", miss_ready, 1);
        chk("no_stray_req", mem_req, 0);
        chk("one_burst", n_bursts - b0, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1234, 0, 1'b0, 0, 99, 32'h0000_1200, 64'h0};
        vecs[1] = '{32'h0000_ABCD, 3, 1'b0, 0, 99, 32'h0000_ABC0, 64'h0F0F_0000_5A5A_0001};
        vecs[2] = '{32'h0010_0008, 1, 1'b1, 5, 99, 32'h0010_0000, 64'hC3C3_C3C3_0000_FFFF};
        vecs[3] = '{32'h2000_007F, 0, 1'b0, 0, 5,  32'h2000_0040, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{32'hFFFF_FFFF, 0, 1'b0, 2, 99, 32'hFFFF_FFC0, 64'hFFFF_0000_FFFF_0000};
        vecs[5] = '{32'h0000_0040, 0, 1'b0, 0, 99, 32'h0000_0040, 64'h7777_0000_1234_0000};
        vecs[6] = '{32'h0000_0080, 0, 1'b0, 0, 99, 32'h0000_0080, 64'hAAAA_0000_0000_0001};
        vecs[7] = '{32'h0000_00C0, 0, 1'b0, 0, 99, 32'h0000_00C0, 64'h5555_0000_0000_0002};

        rst = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rerr   = 1'b0;
        fill_ready = 1'b0;
        step();
        step();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_err", fill_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_data", fill_data, 0);
        rst = 1'b0;
        step();

        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        mem_rerr   = 1'b1;
        step();
        mem_rvalid = 1'b0;
        mem_rerr   = 1'b0;
        chk("idle_rvalid_ready", miss_ready, 1);
        chk("idle_rvalid_data", fill_data, 0);
        chk("idle_rvalid_err", fill_err, 0);

        for (int i = 0; i < 5; i++) run_miss(vecs[i]);

        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1000;
        step();
        miss_valid = 1'b0;
        mem_gnt    = 1'b1;
        step();
        mem_gnt    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0 + 64'(k);
            mem_rerr   = 1'b1;
            step();
        end
        mem_rvalid = 1'b0;
        mem_rerr   = 1'b0;
        chk("pre_rst_not_fill", fill_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_miss_ready", miss_ready, 1);
        chk("abort_fill_valid", fill_valid, 0);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_fill_data", fill_data, 0);
        chk("abort_fill_err", fill_err, 0);
        chk("abort_mem_addr", mem_addr, 0);

        for (int i = 5; i < 8; i++) run_miss(vecs[i]);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
